// File: rtl/ice_uart_tx_arbiter.sv
// Round-robin, frame-granular arbiter sharing one UART TX byte stream among
// NUM_REQ sources, with an idle watchdog that evicts a stalled frame owner.
module ice_uart_tx_arbiter #(
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [8*NUM_REQ-1:0]   req_data,
  input  logic [NUM_REQ-1:0]     req_last,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic [7:0]             tx_data,
  output logic                   tx_valid,
  input  logic                   tx_ready,
  output logic [NUM_REQ-1:0]     grant,
  output logic                   busy,
  output logic                   timeout_err,
  output logic [2:0]             timeout_src
);

  localparam int unsigned IW   = $clog2(NUM_REQ);
  localparam int unsigned CW   = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam int unsigned TLIM = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
  localparam logic [IW-1:0] LAST_INIT = IW'(NUM_REQ - 1);

  typedef enum logic {IDLE, XFER} state_e;

  state_e        state_q, state_d;
  logic [IW-1:0] own_q, own_d;
  logic [IW-1:0] last_q, last_d;
  logic [7:0]    txd_q, txd_d;
  logic          txv_q, txv_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          terr_q, terr_d;
  logic [2:0]    tsrc_q, tsrc_d;

  logic          take, accept;
  logic          own_valid, own_last;
  logic [7:0]    own_data;
  logic [IW-1:0] pick, idx;
  logic          found;

  // First valid requester scanning upward from the one after last_q.
  always_comb begin
    pick  = last_q;
    idx   = '0;
    found = 1'b0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      idx = IW'((32'(last_q) + k) % NUM_REQ);
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  always_comb begin
    own_valid = 1'b0;
    own_last  = 1'b0;
    own_data  = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (own_q == IW'(i)) begin
        own_valid = req_valid[i];
        own_last  = req_last[i];
        own_data  = req_data[8*i +: 8];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    own_d     = own_q;
    last_d    = last_q;
    txd_d     = txd_q;
    txv_d     = txv_q;
    cnt_d     = cnt_q;
    terr_d    = 1'b0;
    tsrc_d    = tsrc_q;
    req_ready = '0;
    take      = ~txv_q | tx_ready;
    accept    = 1'b0;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (found) begin
          state_d = XFER;
          own_d   = pick;
        end
      end
      XFER: begin
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
          req_ready[i] = take && (own_q == IW'(i));
        end
        accept = own_valid & take;
        if (accept) begin
          cnt_d = '0;
          if (own_last) begin
            state_d = IDLE;
            last_d  = own_q;
          end
        end else if (TIMEOUT_CYCLES != 0 && take) begin
          // take low means the sink is stalling, which must not age the frame
          if (cnt_q == CW'(TLIM)) begin
            terr_d  = 1'b1;
            tsrc_d  = 3'(own_q);
            state_d = IDLE;
            last_d  = own_q;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (accept) begin
      txd_d = own_data;
      txv_d = 1'b1;
    end else if (tx_ready) begin
      txv_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      own_q   <= '0;
      last_q  <= LAST_INIT;
      txd_q   <= '0;
      txv_q   <= 1'b0;
      cnt_q   <= '0;
      terr_q  <= 1'b0;
      tsrc_q  <= '0;
    end else begin
      state_q <= state_d;
      own_q   <= own_d;
      last_q  <= last_d;
      txd_q   <= txd_d;
      txv_q   <= txv_d;
      cnt_q   <= cnt_d;
      terr_q  <= terr_d;
      tsrc_q  <= tsrc_d;
    end
  end

  always_comb begin
    grant = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      grant[i] = (state_q == XFER) && (own_q == IW'(i));
    end
  end

  assign busy        = (state_q == XFER);
  assign tx_data     = txd_q;
  assign tx_valid    = txv_q;
  assign timeout_err = terr_q;
  assign timeout_src = tsrc_q;

endmodule

// File: tb/tb_ice_uart_tx_arbiter.sv
// Bench for ice_uart_tx_arbiter: per-source frame queues, a frame-level
// arbitration/handshake model, directed scenarios and randomized traffic.
module tb_ice_uart_tx_arbiter;
  localparam int NR = 4;
  localparam int TO = 8;

  logic            clk = 1'b0;
  logic            resetn;
  logic [NR-1:0]   req_valid;
  logic [8*NR-1:0] req_data;
  logic [NR-1:0]   req_last;
  logic [NR-1:0]   req_ready;
  logic [7:0]      tx_data;
  logic            tx_valid;
  logic            tx_ready;
  logic [NR-1:0]   grant;
  logic            busy;
  logic            timeout_err;
  logic [2:0]      timeout_src;

  ice_uart_tx_arbiter #(.NUM_REQ(NR), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .resetn(resetn),
    .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
    .req_ready(req_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .grant(grant), .busy(busy),
    .timeout_err(timeout_err), .timeout_src(timeout_src)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic [8:0] sbuf [NR][64];
  int         shead [NR];
  int         stail [NR];
  logic [7:0] expq [$];
  int         frame_log [$];
  bit         mute [NR];
  int         drop [NR];
  bit         rnd_gap, rnd_trdy, trdy_low;

  bit m_busy, m_te;
  int m_owner, m_last, m_stall, m_tsrc;

  function automatic int rr_pick(logic [NR-1:0] v, int last);
    for (int k = 1; k <= NR; k++) if (v[(last + k) % NR]) return (last + k) % NR;
    return 0;
  endfunction

  function automatic bit pending();
    for (int i = 0; i < NR; i++) if (shead[i] != stail[i]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic push_byte(int s, logic [7:0] d, bit last);
    sbuf[s][stail[s]] = {last, d};
    stail[s]++;
  endtask

  task automatic push_frame(int s, int len);
    for (int j = 0; j < len; j++) push_byte(s, 8'($urandom), j == len - 1);
  endtask

  task automatic flush_frame(int s);
    logic [8:0] b;
    while (shead[s] != stail[s]) begin
      b = sbuf[s][shead[s]];
      shead[s]++;
      if (b[8]) break;
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_te = 0; m_owner = 0; m_last = NR - 1; m_stall = 0; m_tsrc = 0;
    expq.delete();
    for (int i = 0; i < NR; i++) begin
      shead[i] = 0; stail[i] = 0; mute[i] = 0; drop[i] = 0;
    end
  endtask

  task automatic drive_inputs();
    bit have, v;
    for (int i = 0; i < NR; i++) begin
      have = shead[i] != stail[i];
      v = have && !mute[i];
      if (v && rnd_gap) begin
        if (drop[i] < 2 && $urandom_range(3) == 0) begin v = 0; drop[i]++; end
        else drop[i] = 0;
      end
      req_valid[i] = v;
      req_data[8*i +: 8] = have ? sbuf[i][shead[i]][7:0] : 8'($urandom);
      req_last[i] = have ? sbuf[i][shead[i]][8] : 1'b0;
    end
    tx_ready = trdy_low ? 1'b0 : (rnd_trdy ? 1'($urandom_range(1)) : 1'b1);
  endtask

  task automatic check_pre();
    logic [NR-1:0] exp_rdy;
    bit pend, lastb;
    pend = expq.size() != 0;
    exp_rdy = '0;
    if (m_busy && (!pend || tx_ready)) exp_rdy[m_owner] = 1'b1;
    n_cmp++;
    if (req_ready !== exp_rdy) begin
      n_bad++; $display("FAIL req_ready: got %b expected %b at %0t", req_ready, exp_rdy, $time);
    end
    n_cmp++;
    if (tx_valid !== pend) begin
      n_bad++; $display("FAIL tx_valid: got %b expected %b at %0t", tx_valid, pend, $time);
    end
    if (pend) begin
      n_cmp++;
      if (tx_data !== expq[0]) begin
        n_bad++; $display("FAIL tx_data: got %h expected %h at %0t", tx_data, expq[0], $time);
      end
      if (tx_ready) void'(expq.pop_front());
    end
    m_te = 0;
    if ((req_valid & exp_rdy) != '0) begin
      expq.push_back(sbuf[m_owner][shead[m_owner]][7:0]);
      lastb = sbuf[m_owner][shead[m_owner]][8];
      shead[m_owner]++;
      m_stall = 0;
      if (lastb) begin m_busy = 0; m_last = m_owner; end
    end else if (m_busy) begin
      if (!(pend && !tx_ready)) begin
        m_stall++;
        if (m_stall == TO) begin
          m_te = 1; m_tsrc = m_owner; m_busy = 0; m_last = m_owner; m_stall = 0;
          flush_frame(m_owner);
        end
      end
    end else if (req_valid != '0) begin
      m_owner = rr_pick(req_valid, m_last);
      m_busy = 1; m_stall = 0;
      frame_log.push_back(m_owner);
    end
  endtask

  task automatic check_post();
    logic [NR-1:0] exp_g;
    exp_g = '0;
    if (m_busy) exp_g[m_owner] = 1'b1;
    n_cmp++;
    if (grant !== exp_g) begin
      n_bad++; $display("FAIL grant: got %b expected %b at %0t", grant, exp_g, $time);
    end
    n_cmp++;
    if (busy !== m_busy) begin
      n_bad++; $display("FAIL busy: got %b expected %b at %0t", busy, m_busy, $time);
    end
    n_cmp++;
    if (timeout_err !== m_te) begin
      n_bad++; $display("FAIL timeout_err: got %b expected %b at %0t", timeout_err, m_te, $time);
    end
    n_cmp++;
    if (timeout_src !== 3'(m_tsrc)) begin
      n_bad++; $display("FAIL timeout_src: got %0d expected %0d at %0t", timeout_src, m_tsrc, $time);
    end
  endtask

  task automatic cycle();
    drive_inputs();
    @(negedge clk);
    check_pre();
    @(posedge clk);
    #1;
    check_post();
  endtask

  task automatic run_idle(int budget);
    int n;
    n = 0;
    while ((pending() || m_busy || expq.size() != 0) && n < budget) begin
      cycle();
      n++;
    end
    n_cmp++;
    if (n >= budget) begin
      n_bad++; $display("FAIL drain_budget: used %0d cycles, required fewer than %0d", n, budget);
    end
  endtask

  task automatic apply_reset();
    resetn = 1'b0;
    req_valid = '0; req_last = '0; req_data = '0; tx_ready = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
    @(posedge clk);
    #1;
    check_post();
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    req_valid = '0; req_last = '0; req_data = '0; tx_ready = 1'b1;
    #3;
    n_cmp++;
    if ({req_ready, tx_data, tx_valid, grant, busy, timeout_err, timeout_src} !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs: got rdy=%b data=%h v=%b g=%b busy=%b te=%b ts=%0d required all zero",
               req_ready, tx_data, tx_valid, grant, busy, timeout_err, timeout_src);
    end
    apply_reset();
  endtask

  task automatic test_single_frame();
    logic [7:0] seq [3];
    seq[0] = 8'hA1; seq[1] = 8'hA2; seq[2] = 8'hA3;
    for (int j = 0; j < 3; j++) push_byte(2, seq[j], j == 2);
    cycle();
    n_cmp++;
    if (grant !== 4'b0100) begin
      n_bad++; $display("FAIL single_grant: got %b expected 0100", grant);
    end
    for (int j = 0; j < 3; j++) begin
      cycle();
      n_cmp++;
      if (tx_valid !== 1'b1 || tx_data !== seq[j]) begin
        n_bad++; $display("FAIL single_byte%0d: got v=%b %h expected v=1 %h", j, tx_valid, tx_data, seq[j]);
      end
    end
    n_cmp++;
    if (grant !== '0 || busy !== 1'b0) begin
      n_bad++; $display("FAIL single_release: got grant=%b busy=%b expected 0000/0", grant, busy);
    end
    run_idle(20);
  endtask

  task automatic test_fairness();
    apply_reset();
    for (int f = 0; f < 3; f++) begin
      push_frame(0, 2);
      push_frame(1, 2);
    end
    frame_log.delete();
    run_idle(200);
    n_cmp++;
    if (frame_log.size() != 6) begin
      n_bad++; $display("FAIL fair_count: got %0d frames expected 6", frame_log.size());
    end else begin
      for (int f = 0; f < 6; f++) begin
        n_cmp++;
        if (frame_log[f] != f % 2) begin
          n_bad++; $display("FAIL fair_order%0d: got %0d expected %0d", f, frame_log[f], f % 2);
        end
      end
    end
  endtask

  task automatic test_wraparound();
    push_frame(3, 2);
    run_idle(50);
    frame_log.delete();
    push_frame(1, 2);
    push_frame(3, 2);
    run_idle(50);
    n_cmp++;
    if (frame_log.size() != 2 || frame_log[0] != 1 || frame_log[1] != 3) begin
      n_bad++;
      $display("FAIL wrap_order: got %0d frames first=%0d expected 2 frames 1 then 3",
               frame_log.size(), frame_log.size() > 0 ? frame_log[0] : -1);
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] b1;
    push_frame(0, 4);
    b1 = sbuf[0][shead[0] + 1][7:0];
    repeat (3) cycle();
    trdy_low = 1;
    for (int c = 0; c < 10; c++) begin
      cycle();
      n_cmp++;
      if (tx_data !== b1 || tx_valid !== 1'b1 || req_ready !== '0) begin
        n_bad++;
        $display("FAIL bp_hold%0d: got data=%h v=%b rdy=%b expected data=%h v=1 rdy=0000",
                 c, tx_data, tx_valid, req_ready, b1);
      end
    end
    trdy_low = 0;
    run_idle(50);
  endtask

  task automatic test_timeout();
    int n;
    push_byte(3, 8'h3C, 1'b0);
    push_byte(3, 8'h3D, 1'b1);
    push_frame(0, 2);
    cycle();
    n_cmp++;
    if (grant !== 4'b1000) begin
      n_bad++; $display("FAIL to_grant3: got %b expected 1000", grant);
    end
    cycle();
    mute[3] = 1;
    n = 0;
    do begin
      cycle();
      n++;
    end while (timeout_err !== 1'b1 && n < 20);
    n_cmp++;
    if (n != TO) begin
      n_bad++; $display("FAIL to_latency: got %0d cycles expected %0d", n, TO);
    end
    n_cmp++;
    if (timeout_src !== 3'd3) begin
      n_bad++; $display("FAIL to_src: got %0d expected 3", timeout_src);
    end
    mute[3] = 0;
    cycle();
    n_cmp++;
    if (grant !== 4'b0001 || timeout_err !== 1'b0) begin
      n_bad++; $display("FAIL to_regrant: got grant=%b te=%b expected 0001/0", grant, timeout_err);
    end
    run_idle(50);
  endtask

  task automatic test_reset_midframe();
    push_frame(2, 4);
    repeat (2) cycle();
    drive_inputs();
    #2;
    resetn = 1'b0;
    #1;
    n_cmp++;
    if ({req_ready, tx_data, tx_valid, grant, busy, timeout_err, timeout_src} !== '0) begin
      n_bad++;
      $display("FAIL midreset_outputs: got rdy=%b data=%h v=%b g=%b busy=%b te=%b ts=%0d required all zero",
               req_ready, tx_data, tx_valid, grant, busy, timeout_err, timeout_src);
    end
    apply_reset();
    for (int i = 0; i < NR; i++) push_frame(i, 2);
    frame_log.delete();
    run_idle(100);
    n_cmp++;
    if (frame_log.size() != NR) begin
      n_bad++; $display("FAIL midreset_count: got %0d frames expected %0d", frame_log.size(), NR);
    end else begin
      for (int i = 0; i < NR; i++) begin
        n_cmp++;
        if (frame_log[i] != i) begin
          n_bad++; $display("FAIL midreset_order%0d: got %0d expected %0d", i, frame_log[i], i);
        end
      end
    end
  endtask

  task automatic test_random();
    rnd_gap = 1;
    rnd_trdy = 1;
    for (int r = 0; r < 30; r++) begin
      for (int i = 0; i < NR; i++) begin
        shead[i] = 0; stail[i] = 0;
        if ($urandom_range(1) == 1) begin
          for (int f = 0; f <= int'($urandom_range(2)); f++) push_frame(i, 1 + int'($urandom_range(3)));
        end
      end
      run_idle(600);
    end
    rnd_gap = 0;
    rnd_trdy = 0;
  endtask

  initial begin
    rnd_gap = 0; rnd_trdy = 0; trdy_low = 0;
    model_reset();
    test_reset();
    test_single_frame();
    test_fairness();
    test_wraparound();
    test_backpressure();
    test_timeout();
    test_reset_midframe();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_time_limit: simulation exceeded 500000 time units");
    $fatal(1);
  end

endmodule

// File: doc/ice_uart_tx_arbiter.md
Name: ice_uart_tx_arbiter

Overview:
- Shares the single USB UART transmit byte stream among NUM_REQ framed byte sources inside the ICE bus, such as PINT responses, I2C/GOC replies and debug messages.
- Grants round-robin and holds the grant for a whole frame, so bytes from different sources never interleave.
- A stalled source is evicted by an idle-timeout watchdog.
- Sits between the message sources and the UART transmitter.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- TIMEOUT_CYCLES, 65535, mid-frame idle cycles before the grant is forcibly released; 0 disables the watchdog.

Ports:
- clk  input  1  system clock.
- resetn  input  1  asynchronous active-low reset.
- req_valid  input  NUM_REQ  per-requester byte valid.
- req_data  input  8*NUM_REQ  per-requester byte; requester i uses bits [8i+7:8i].
- req_last  input  NUM_REQ  byte is the final byte of its frame.
- req_ready  output  NUM_REQ  byte accepted when valid&ready.
- tx_data  output  8  byte to the UART transmitter.
- tx_valid  output  1  tx_data valid.
- tx_ready  input  1  UART transmitter accepts the byte.
- grant  output  NUM_REQ  one-hot current owner; all zero when idle.
- busy  output  1  a frame is in progress.
- timeout_err  output  1  one-cycle pulse when a frame is aborted.
- timeout_src  output  3  index of the last aborted requester; holds until the next abort.

Behaviour:
- Reset (resetn low, asynchronous) drives every output low. State becomes IDLE, last_grant = NUM_REQ-1 (so requester 0 has first priority), and the output register is emptied. Reset mid-frame discards any partial frame and any pending output byte.
- States:
  - IDLE. If any req_valid is high, choose the first requester with req_valid high scanning last_grant+1, last_grant+2, ... wrapping modulo NUM_REQ. Register grant and busy=1, go to XFER. This costs one cycle of arbitration latency.
  - XFER. Only grant[g] may have req_ready high: req_ready[g] = ~tx_valid | tx_ready. All other req_ready are 0.
- Byte transfer:
  - An accept (req_valid[g]&req_ready[g]) loads req_data[g] into tx_data and sets tx_valid=1 on the next edge.
  - tx_valid stays high and tx_data stays stable until tx_ready.
  - tx_ready together with no new accept clears tx_valid.
  - Sustained throughput is 1 byte/cycle when tx_ready is held high.
- End of frame: an accept with req_last[g]=1 returns to IDLE on the next edge, clears grant and busy, and sets last_grant=g. The final byte drains from the output register independently. A new frame may be granted while that byte is still pending, since the new owner's req_ready follows the register rule.
- Watchdog:
  - In XFER the counter increments on each cycle without an accept and clears on an accept or on entry to XFER.
  - Waiting on tx_ready with tx_valid=1 does NOT count (counter holds), so only source stalls cause aborts.
  - When the count reaches TIMEOUT_CYCLES: pulse timeout_err for one cycle, load timeout_src=g, go to IDLE, set last_grant=g. Bytes already accepted still drain.
  - Counter width is clog2(TIMEOUT_CYCLES+1).
- Simultaneous events:
  - An accept on the cycle the count would expire counts as an accept; there is no abort.
  - req_last combined with an expiry is impossible, since the expiry requires no accept.
  - A requester's req_valid dropping mid-frame does not release the grant.

Test Plan:
- Single frame: requester 2 sends 0xA1,0xA2,0xA3(last) with tx_ready=1 -> grant=0100 one cycle after first valid; tx_data shows A1,A2,A3 on consecutive cycles; grant and busy return to 0 the cycle after A3 is accepted.
- Fairness: requesters 0 and 1 both hold 2-byte frames continuously -> frames alternate 0,1,0,1 with no byte interleaving; from reset, requester 0 wins first.
- Wrap-around: last_grant=3 with requesters 1 and 3 valid -> requester 1 is granted.
- Backpressure: tx_ready low for 5 cycles mid-frame -> tx_data held stable, req_ready[g]=0, watchdog does not advance; no loss or duplication once tx_ready rises.
- Timeout with TIMEOUT_CYCLES=8: requester 3 sends one non-last byte, then drops req_valid -> timeout_err pulses 8 cycles after the accept, timeout_src=3, next pending requester (0) is granted.
- Reset mid-frame: resetn low during byte 2 of a 4-byte frame -> all outputs 0 immediately; after release, requester 0 has first priority.
